// File: rtl/clk_div_bank.sv
// Bank of independent 50%-duty clock dividers with handshake configuration.
// Reconfiguring a running channel takes effect only at its high-to-low point, so no runt phases occur.
module clk_div_bank #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8,
  parameter int CH_W   = 2
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);

  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] pen_q, pen_d;
  logic [DIV_W-1:0]  div_q [NUM_CH];
  logic [DIV_W-1:0]  div_d [NUM_CH];
  logic [DIV_W-1:0]  cnt_q [NUM_CH];
  logic [DIV_W-1:0]  cnt_d [NUM_CH];
  logic [DIV_W-1:0]  pdiv_q[NUM_CH];
  logic [DIV_W-1:0]  pdiv_d[NUM_CH];
  logic              accept;

  // Out-of-range channel selects never match, so they stay ready and are dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = ~pend_q[i];
    end
  end

  assign accept = cfg_valid & cfg_ready;

  always_comb begin
    en_d   = en_q;
    clk_d  = clk_q;
    tick_d = '0;
    pend_d = pend_q;
    pen_d  = pen_q;
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i]  = div_q[i];
      cnt_d[i]  = cnt_q[i];
      pdiv_d[i] = pdiv_q[i];
      if (en_q[i]) begin
        if (cnt_q[i] == div_q[i]) begin
          cnt_d[i] = '0;
          if (clk_q[i] && pend_q[i]) begin
            clk_d[i]  = 1'b0;
            div_d[i]  = pdiv_q[i];
            en_d[i]   = pen_q[i];
            pend_d[i] = 1'b0;
          end else begin
            clk_d[i]  = ~clk_q[i];
            tick_d[i] = ~clk_q[i];
          end
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
        end
        // A running channel only queues the new setting; cfg_ready guarantees pend_q was clear.
        if (accept && cfg_ch == CH_W'(i)) begin
          pend_d[i] = 1'b1;
          pdiv_d[i] = cfg_div;
          pen_d[i]  = cfg_en;
        end
      end else begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        if (accept && cfg_ch == CH_W'(i)) begin
          div_d[i] = cfg_div;
          en_d[i]  = cfg_en;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= '0;
      clk_q  <= '0;
      tick_q <= '0;
      pend_q <= '0;
      pen_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]  <= '0;
        cnt_q[i]  <= '0;
        pdiv_q[i] <= '0;
      end
    end else begin
      en_q   <= en_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
      pen_q  <= pen_d;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]  <= div_d[i];
        cnt_q[i]  <= cnt_d[i];
        pdiv_q[i] <= pdiv_d[i];
      end
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pend    = pend_q;

endmodule
